// File: rtl/pic_priority_core.sv
// Interrupt-priority engine: IRR/IMR/ISR, fully-nested resolver, two-pulse INTA sequencer, EOI.
// Define PIC_ROTATE_PRIORITY_EN to make each non-specific EOI rotate the priority order.
module pic_priority_core #(
   parameter int unsigned N_IRQ = 8,
   parameter int unsigned ID_W  = $clog2(N_IRQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] ir,
   input  logic             ltim,
   input  logic             imr_we,
   input  logic [N_IRQ-1:0] imr_wdata,
   input  logic [7:0]       vec_base,
   input  logic             inta,
   input  logic             eoi,
   input  logic             seoi,
   input  logic [ID_W-1:0]  seoi_id,
   output logic             int_out,
   output logic [7:0]       vector,
   output logic             vector_valid,
   output logic [N_IRQ-1:0] irr,
   output logic [N_IRQ-1:0] imr,
   output logic [N_IRQ-1:0] isr
);

   localparam logic [N_IRQ-1:0] Bit0 = N_IRQ'(1);
   localparam logic [ID_W:0]    NIrq = (ID_W+1)'(N_IRQ);

   typedef enum logic [0:0] {StIdle, StAck1} state_e;

   state_e           state_q;
   logic [N_IRQ-1:0] ir_q, irr_q, imr_q, isr_q;
   logic [N_IRQ-1:0] irr_d, isr_d, req;
   logic [N_IRQ-1:0] ack_mask, eoi_mask, seoi_mask;
   logic [ID_W-1:0]  id_q, win_id, eoi_id, low_ptr;
   logic             win_valid, eoi_valid, ack1, idle_next;
   logic             int_out_q, int_out_d, vector_valid_q;
   logic [7:0]       vector_q;

`ifdef PIC_ROTATE_PRIORITY_EN
   logic [ID_W-1:0] ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= ID_W'(N_IRQ - 1);
      end else if (eoi && eoi_valid) begin
         ptr_q <= eoi_id;
      end
   end

   assign low_ptr = ptr_q;
`else
   assign low_ptr = ID_W'(N_IRQ - 1);
`endif

   assign req = irr_q & ~imr_q;

   // Walk channels from highest to lowest priority; the first in-service bit blocks
   // everything below it and is also the non-specific EOI target.
   always_comb begin
      logic [ID_W:0] pos;
      win_valid = 1'b0;
      win_id    = '0;
      eoi_valid = 1'b0;
      eoi_id    = '0;
      pos       = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         pos = {1'b0, low_ptr} + (ID_W+1)'(k) + (ID_W+1)'(1);
         if (pos >= NIrq) pos = pos - NIrq;
         if (!eoi_valid && isr_q[pos[ID_W-1:0]]) begin
            eoi_valid = 1'b1;
            eoi_id    = pos[ID_W-1:0];
         end else if (!eoi_valid && !win_valid && req[pos[ID_W-1:0]]) begin
            win_valid = 1'b1;
            win_id    = pos[ID_W-1:0];
         end
      end
   end

   always_comb begin
      ack1      = (state_q == StIdle) && inta;
      ack_mask  = (ack1 && win_valid) ? (Bit0 << win_id) : '0;
      eoi_mask  = (eoi && eoi_valid) ? (Bit0 << eoi_id) : '0;
      seoi_mask = seoi ? (Bit0 << seoi_id) : '0;
      isr_d     = (isr_q & ~eoi_mask & ~seoi_mask) | ack_mask;
      // Edge set is OR'd in after the ACK1 clear so a coincident new edge survives.
      irr_d     = ltim ? (ir & ~ack_mask) : ((irr_q & ~ack_mask) | (ir & ~ir_q));
      idle_next = ((state_q == StIdle) && !inta) || ((state_q == StAck1) && inta);
      int_out_d = idle_next && win_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         ir_q           <= '0;
         irr_q          <= '0;
         imr_q          <= '1;
         isr_q          <= '0;
         id_q           <= '0;
         int_out_q      <= 1'b0;
         vector_q       <= '0;
         vector_valid_q <= 1'b0;
      end else begin
         ir_q           <= ir;
         irr_q          <= irr_d;
         isr_q          <= isr_d;
         int_out_q      <= int_out_d;
         vector_valid_q <= 1'b0;
         if (imr_we) imr_q <= imr_wdata;
         unique case (state_q)
            StIdle: begin
               if (inta) begin
                  state_q <= StAck1;
                  id_q    <= win_valid ? win_id : ID_W'(N_IRQ - 1);
               end
            end
            StAck1: begin
               if (inta) begin
                  state_q        <= StIdle;
                  vector_q       <= vec_base + 8'(id_q);
                  vector_valid_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign int_out      = int_out_q;
   assign vector       = vector_q;
   assign vector_valid = vector_valid_q;
   assign irr          = irr_q;
   assign imr          = imr_q;
   assign isr          = isr_q;

endmodule

// File: tb/tb_pic_priority_core.sv
// Bench for pic_priority_core: directed scenarios plus random traffic against a
// rank-based reference model of the request/in-service bookkeeping.
module tb_pic_priority_core;

   localparam int N    = 8;
   localparam int ID_W = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ltim = 1'b0;
   logic            imr_we = 1'b0;
   logic            inta = 1'b0;
   logic            eoi = 1'b0;
   logic            seoi = 1'b0;
   logic [N-1:0]    ir = '0;
   logic [N-1:0]    imr_wdata = '0;
   logic [7:0]      vec_base = 8'h40;
   logic [ID_W-1:0] seoi_id = '0;
   logic            int_out, vector_valid;
   logic [7:0]      vector;
   logic [N-1:0]    irr, imr, isr;

   pic_priority_core #(.N_IRQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ir          (ir),
      .ltim        (ltim),
      .imr_we      (imr_we),
      .imr_wdata   (imr_wdata),
      .vec_base    (vec_base),
      .inta        (inta),
      .eoi         (eoi),
      .seoi        (seoi),
      .seoi_id     (seoi_id),
      .int_out     (int_out),
      .vector      (vector),
      .vector_valid(vector_valid),
      .irr         (irr),
      .imr         (imr),
      .isr         (isr)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state
   int m_irr, m_imr, m_isr, m_irprev, m_id, m_ptr, m_vec, m_busy, m_int, m_vv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_irr = 0; m_imr = (1 << N) - 1; m_isr = 0; m_irprev = 0; m_id = 0;
      m_ptr = N - 1; m_vec = 0; m_busy = 0; m_int = 0; m_vv = 0;
   endtask

   // 0 = most urgent; priority runs circularly from the channel after m_ptr
   function automatic int rank(input int ch);
      return (ch - m_ptr - 1 + 2 * N) % N;
   endfunction

   task automatic model_step();
      int top_isr = N;
      int eoi_ch  = -1;
      int win     = -1;
      int ack_bit = 0;
      int nxt_isr, nxt_irr, idle_after;
      for (int i = 0; i < N; i++)
         if (m_isr[i] && rank(i) < top_isr) begin
            top_isr = rank(i);
            eoi_ch  = i;
         end
      for (int i = 0; i < N; i++)
         if (m_irr[i] && !m_imr[i] && rank(i) < top_isr && (win < 0 || rank(i) < rank(win)))
            win = i;
      if (m_busy == 0 && inta && win >= 0) ack_bit = 1 << win;
      nxt_isr = m_isr;
      if (eoi && eoi_ch >= 0) nxt_isr = nxt_isr & ~(1 << eoi_ch);
      if (seoi) nxt_isr = nxt_isr & ~(1 << seoi_id);
      nxt_isr = nxt_isr | ack_bit;
      if (ltim) nxt_irr = int'(ir) & ~ack_bit;
      else nxt_irr = (m_irr & ~ack_bit) | (int'(ir) & ~m_irprev);
`ifdef PIC_ROTATE_PRIORITY_EN
      if (eoi && eoi_ch >= 0) m_ptr = eoi_ch;
`endif
      idle_after = ((m_busy == 0 && !inta) || (m_busy == 1 && inta)) ? 1 : 0;
      m_int = (idle_after == 1 && win >= 0) ? 1 : 0;
      m_vv  = 0;
      if (inta) begin
         if (m_busy == 0) begin
            m_busy = 1;
            m_id   = (win >= 0) ? win : N - 1;
         end else begin
            m_busy = 0;
            m_vec  = (int'(vec_base) + m_id) % 256;
            m_vv   = 1;
         end
      end
      if (imr_we) m_imr = int'(imr_wdata);
      m_isr    = nxt_isr;
      m_irr    = nxt_irr;
      m_irprev = int'(ir);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check("int_out", 32'(int_out), 32'(m_int));
      check("vector_valid", 32'(vector_valid), 32'(m_vv));
      check("vector", 32'(vector), 32'(m_vec));
      check("irr", 32'(irr), 32'(m_irr));
      check("imr", 32'(imr), 32'(m_imr));
      check("isr", 32'(isr), 32'(m_isr));
   endtask

   task automatic pulse_ir(input logic [N-1:0] v);
      ir = v;
      step();
      ir = '0;
      step();
   endtask

   task automatic serve(input logic [7:0] exp_vec);
      inta = 1'b1; step();
      inta = 1'b0; step();
      inta = 1'b1; step();
      check("ack_vector", 32'(vector), 32'(exp_vec));
      check("ack_strobe", 32'(vector_valid), 32'd1);
      inta = 1'b0; step();
   endtask

   task automatic do_eoi();
      eoi = 1'b1; step();
      eoi = 1'b0;
   endtask

   task automatic mid_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_int_out", 32'(int_out), 32'd0);
      check("rst_vector", 32'(vector), 32'd0);
      check("rst_vector_valid", 32'(vector_valid), 32'd0);
      check("rst_irr", 32'(irr), 32'd0);
      check("rst_imr", 32'(imr), 32'hFF);
      check("rst_isr", 32'(isr), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_int_out", 32'(int_out), 32'd0);
      check("reset_vector_valid", 32'(vector_valid), 32'd0);
      check("reset_vector", 32'(vector), 32'd0);
      check("reset_imr", 32'(imr), 32'hFF);
      check("reset_isr", 32'(isr), 32'd0);
      rst_n = 1'b1;

      // Single edge request on channel 3
      imr_we = 1'b1; imr_wdata = 8'h00; step(); imr_we = 1'b0;
      pulse_ir(8'h08);
      check("t1_int_out", 32'(int_out), 32'd1);
      inta = 1'b1; step();
      check("t1_isr", 32'(isr), 32'h08);
      check("t1_irr", 32'(irr), 32'h00);
      inta = 1'b0; step();
      inta = 1'b1; step();
      check("t1_vector", 32'(vector), 32'h43);
      inta = 1'b0; step();
      do_eoi();

      // Two simultaneous edges: 2 served first, 5 waits for the EOI
      pulse_ir(8'h24);
      check("t2_int_out", 32'(int_out), 32'd1);
      serve(8'h42);
      check("t2_nested_hold", 32'(int_out), 32'd0);
      check("t2_irr_pending", 32'(irr), 32'h20);
      do_eoi();
      step();
      check("t2_after_eoi", 32'(int_out), 32'd1);
      serve(8'h45);
      do_eoi();

      // Masked request stays latched, fires once unmasked
      imr_we = 1'b1; imr_wdata = 8'h10; step(); imr_we = 1'b0;
      pulse_ir(8'h10);
      check("t3_masked_int", 32'(int_out), 32'd0);
      check("t3_irr", 32'(irr), 32'h10);
      imr_we = 1'b1; imr_wdata = 8'h00; step(); imr_we = 1'b0;
      check("t3_unmask_lag", 32'(int_out), 32'd0);
      step();
      check("t3_unmasked_int", 32'(int_out), 32'd1);
      serve(8'h44);
      do_eoi();

      // Level request withdrawn before INTA: spurious vector
      ltim = 1'b1; ir = 8'h02;
      step(); step();
      check("t4_int_out", 32'(int_out), 32'd1);
      ir = 8'h00; step();
      inta = 1'b1; step();
      check("t4_isr", 32'(isr), 32'h00);
      inta = 1'b0; step();
      inta = 1'b1; step();
      check("t4_vector", 32'(vector), 32'h47);
      inta = 1'b0; step();
      ltim = 1'b0; step();

      // Fully-nested blocking and specific EOI
      pulse_ir(8'h10);
      serve(8'h44);
      check("t5_isr4", 32'(isr), 32'h10);
      pulse_ir(8'h40);
      check("t5_lower_blocked", 32'(int_out), 32'd0);
      pulse_ir(8'h02);
      check("t5_higher_fires", 32'(int_out), 32'd1);
      serve(8'h41);
      check("t5_isr_nested", 32'(isr), 32'h12);
      do_eoi();
      check("t5_eoi_top", 32'(isr), 32'h10);
      seoi = 1'b1; seoi_id = 3'd4; step(); seoi = 1'b0;
      check("t5_seoi", 32'(isr), 32'h00);
      step();
      check("t5_pending6", 32'(int_out), 32'd1);
      serve(8'h46);
      do_eoi();

`ifdef PIC_ROTATE_PRIORITY_EN
      pulse_ir(8'h01);
      serve(8'h40);
      do_eoi();
      pulse_ir(8'h03);
      serve(8'h41);
      do_eoi();
`endif

      // Reset in the middle of the INTA handshake
      pulse_ir(8'h01);
      inta = 1'b1; step(); inta = 1'b0;
      mid_reset();
      inta = 1'b1; step();
      check("t6_no_stale_strobe", 32'(vector_valid), 32'd0);
      inta = 1'b0; step();
      inta = 1'b1; step(); inta = 1'b0; step();
      imr_we = 1'b1; imr_wdata = 8'h00; step(); imr_we = 1'b0;

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 800 == 0) ltim = 1'($urandom_range(0, 1));
         if (c == 2000) vec_base = 8'hFC;
         ir        = N'($urandom & $urandom & $urandom);
         inta      = ($urandom_range(0, 3) == 0);
         eoi       = ($urandom_range(0, 5) == 0);
         seoi      = ($urandom_range(0, 9) == 0);
         seoi_id   = ID_W'($urandom);
         imr_we    = ($urandom_range(0, 29) == 0);
         imr_wdata = N'($urandom & $urandom);
         if (c == 2500) mid_reset();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
